// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg: shared widths, config record and config validity check
package clk_en_gen_pkg;
   localparam int ACC_W_DEF = 16;
   localparam int LOCK_W = 8;
   typedef struct packed {
      logic [2:0]           ch;
      logic [ACC_W_DEF-1:0] num;
      logic [ACC_W_DEF-1:0] den;
   } cfg_t;
   function automatic logic cfg_ok(input logic [31:0] num, input logic [31:0] den);
      return num != 0 && num <= den;
   endfunction
endpackage

// File: rtl/clk_en_gen_ce_channel.sv
// ce_channel: one fractional num/den accumulator with enable, toggle and lock count
module ce_channel import clk_en_gen_pkg::*; #(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LOCK_CNT = 4,
   parameter logic [ACC_W-1:0] DEF_NUM = ACC_W'(1),
   parameter logic [ACC_W-1:0] DEF_DEN = ACC_W'(2)
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             ld,
   input  logic             sync,
   input  logic [ACC_W-1:0] ld_num,
   input  logic [ACC_W-1:0] ld_den,
   output logic             ce,
   output logic             tog,
   output logic             lk_done
);
   logic [ACC_W-1:0] num, den, acc;
   logic [LOCK_W-1:0] lock;
   logic [ACC_W:0] sum;
   logic hit;
   assign sum = {1'b0, acc} + {1'b0, num};
   assign hit = sum >= {1'b0, den};
   assign lk_done = lock == LOCK_W'(LOCK_CNT);
   always_ff @(posedge refclk) begin
      if (rst) begin
         num <= DEF_NUM;
         den <= DEF_DEN;
         acc <= '0;
         lock <= '0;
         ce <= 1'b0;
         tog <= 1'b0;
      end else if (ld) begin
         num <= ld_num;
         den <= ld_den;
         acc <= '0;
         lock <= '0;
         ce <= 1'b0;
      end else if (sync) begin
         acc <= '0;
         ce <= 1'b0;
      end else begin
         // sum < den on a miss and sum - den < den on a hit, so both fit in ACC_W
         acc <= hit ? ACC_W'(sum - {1'b0, den}) : ACC_W'(sum);
         ce <= hit;
         if (hit) begin
            tog <= ~tog;
            if (!lk_done) lock <= lock + 1'b1;
         end
      end
   end
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: NUM_CH fractional clock enables with config handshake and aggregate lock
module clk_en_gen import clk_en_gen_pkg::*; #(
   parameter int NUM_CH = 2,
   parameter int ACC_W = ACC_W_DEF,
   parameter int LOCK_CNT = 4,
   parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM = {NUM_CH{ACC_W'(1)}},
   parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN = {NUM_CH{ACC_W'(2)}}
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_ch,
   input  logic [ACC_W-1:0]  cfg_num,
   input  logic [ACC_W-1:0]  cfg_den,
   output logic              cfg_err,
   input  logic              phase_sync,
   output logic [NUM_CH-1:0] ce_o,
   output logic [NUM_CH-1:0] tog_o,
   output logic              locked
);
   logic accept, ok, ld_any;
   logic [NUM_CH-1:0] lk_done;
   assign accept = cfg_valid && cfg_ready;
   assign ok = cfg_ok(32'(cfg_num), 32'(cfg_den)) && (32'(cfg_ch) < NUM_CH);
   assign ld_any = accept && ok;
   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         ce_channel #(
            .ACC_W(ACC_W),
            .LOCK_CNT(LOCK_CNT),
            .DEF_NUM(DEF_NUM[i*ACC_W +: ACC_W]),
            .DEF_DEN(DEF_DEN[i*ACC_W +: ACC_W])
         ) u_ch (
            .refclk(refclk),
            .rst(rst),
            .ld(ld_any && cfg_ch == 3'(i)),
            .sync(phase_sync),
            .ld_num(cfg_num),
            .ld_den(cfg_den),
            .ce(ce_o[i]),
            .tog(tog_o[i]),
            .lk_done(lk_done[i])
         );
      end
   endgenerate
   // a load drops locked on the same edge that clears the channel's lock count
   always_ff @(posedge refclk) begin
      if (rst) begin
         cfg_ready <= 1'b1;
         cfg_err <= 1'b0;
         locked <= 1'b0;
      end else begin
         cfg_ready <= !accept;
         cfg_err <= accept && !ok;
         locked <= !ld_any && &lk_done;
      end
   end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: closed-form rate model compared every cycle plus directed literal checks
module tb_clk_en_gen;
   import clk_en_gen_pkg::*;
   localparam int NUM_CH = 2;
   localparam int LOCK_CNT = 4;
   logic refclk = 0, rst = 0, cfg_valid = 0, phase_sync = 0;
   logic [2:0] cfg_ch = 0;
   logic [15:0] cfg_num = 0, cfg_den = 0;
   logic cfg_ready, cfg_err, locked;
   logic [NUM_CH-1:0] ce_o, tog_o;
   int n_vec = 0, n_err = 0;

   clk_en_gen #(.NUM_CH(NUM_CH), .LOCK_CNT(LOCK_CNT)) dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
      .phase_sync(phase_sync), .ce_o(ce_o), .tog_o(tog_o), .locked(locked)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // model: channel i enables on step n since its last clear iff floor(n*num/den) increases
   longint m_num[NUM_CH], m_den[NUM_CH], m_n[NUM_CH];
   int m_cnt[NUM_CH], m_tot[NUM_CH];
   logic m_ce[NUM_CH];
   logic m_rdy, m_err, m_locked, m_live = 0;
   always @(posedge refclk) begin
      logic acc, ok, all_lk;
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_num[c] = 1; m_den[c] = 2; m_n[c] = 0; m_cnt[c] = 0; m_tot[c] = 0; m_ce[c] = 0;
         end
         m_rdy = 1; m_err = 0; m_locked = 0; m_live = 1;
      end else if (m_live) begin
         acc = cfg_valid && m_rdy;
         ok = cfg_ok(32'(cfg_num), 32'(cfg_den)) && cfg_ch < NUM_CH;
         all_lk = 1;
         for (int c = 0; c < NUM_CH; c++) if (m_cnt[c] < LOCK_CNT) all_lk = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (acc && ok && cfg_ch == c) begin
               m_num[c] = cfg_num; m_den[c] = cfg_den; m_n[c] = 0; m_cnt[c] = 0; m_ce[c] = 0;
            end else if (phase_sync) begin
               m_n[c] = 0; m_ce[c] = 0;
            end else begin
               m_n[c]++;
               m_ce[c] = (m_n[c] * m_num[c]) / m_den[c] != ((m_n[c] - 1) * m_num[c]) / m_den[c];
               if (m_ce[c]) begin m_cnt[c]++; m_tot[c]++; end
            end
         end
         m_locked = !(acc && ok) && all_lk;
         m_err = acc && !ok;
         m_rdy = !acc;
      end
      #1;
      if (m_live) begin
         for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("model ce_o[%0d]", c), 32'(ce_o[c]), 32'(m_ce[c]));
            chk($sformatf("model tog_o[%0d]", c), 32'(tog_o[c]), 32'(m_tot[c] % 2));
         end
         chk("model locked", 32'(locked), 32'(m_locked));
         chk("model cfg_ready", 32'(cfg_ready), 32'(m_rdy));
         chk("model cfg_err", 32'(cfg_err), 32'(m_err));
      end
   end

   task tick;
      @(posedge refclk);
      #2;
   endtask

   task wr(input cfg_t c);
      cfg_valid = 1; cfg_ch = c.ch; cfg_num = c.num; cfg_den = c.den;
      tick;
      cfg_valid = 0;
   endtask

   task chk_reset_state;
      chk("rst ce_o", 32'(ce_o), 0);
      chk("rst tog_o", 32'(tog_o), 0);
      chk("rst locked", 32'(locked), 0);
      chk("rst cfg_ready", 32'(cfg_ready), 1);
      chk("rst cfg_err", 32'(cfg_err), 0);
   endtask

   logic ce0[1:30], ce1[1:30], lk[1:30], tg0[1:30];
   int cnt0, cnt1;

   task run(input int k);
      for (int e = 1; e <= k; e++) begin
         tick;
         ce0[e] = ce_o[0]; ce1[e] = ce_o[1]; lk[e] = locked; tg0[e] = tog_o[0];
      end
   endtask

   task count(input int k);
      cnt0 = 0; cnt1 = 0;
      for (int e = 0; e < k; e++) begin
         tick;
         cnt0 += int'(ce_o[0]); cnt1 += int'(ce_o[1]);
      end
   endtask

   initial begin
      #2;
      rst = 1;
      tick; tick;
      rst = 0;
      chk_reset_state;
      run(9);
      chk("def ce e1", 32'(ce0[1]), 0);
      chk("def ce e2", 32'(ce0[2]), 1);
      chk("def ce e3", 32'(ce0[3]), 0);
      chk("def ce e4", 32'(ce0[4]), 1);
      chk("def tog e2", 32'(tg0[2]), 1);
      chk("def tog e3", 32'(tg0[3]), 1);
      chk("def tog e4", 32'(tg0[4]), 0);
      chk("def locked e8", 32'(lk[8]), 0);
      chk("def locked e9", 32'(lk[9]), 1);

      wr('{3'd1, 16'd21, 16'd100});
      chk("21/100 locked drop", 32'(locked), 0);
      count(100);
      chk("21/100 window1", cnt1, 21);
      chk("21/100 ch0 rate", cnt0, 50);
      chk("21/100 relock", 32'(locked), 1);
      tick; tick; tick;
      count(100);
      chk("21/100 window2", cnt1, 21);

      cfg_valid = 1; cfg_ch = 0; cfg_num = 1; cfg_den = 3;
      tick;
      chk("b2b ready low", 32'(cfg_ready), 0);
      cfg_ch = 1; cfg_num = 1; cfg_den = 5;
      tick;
      chk("b2b ready back", 32'(cfg_ready), 1);
      tick;
      chk("b2b second accept", 32'(cfg_ready), 0);
      cfg_valid = 0;
      tick;
      chk("b2b idle ready", 32'(cfg_ready), 1);
      count(40);

      wr('{3'd0, 16'd5, 16'd3});
      chk("err num>den", 32'(cfg_err), 1);
      chk("err keeps locked", 32'(locked), 1);
      tick;
      chk("err one cycle", 32'(cfg_err), 0);
      wr('{3'd7, 16'd1, 16'd2});
      chk("err bad ch", 32'(cfg_err), 1);
      tick;
      wr('{3'd1, 16'd0, 16'd4});
      chk("err num=0", 32'(cfg_err), 1);
      count(30);
      chk("err ch0 rate kept", cnt0, 10);
      chk("err ch1 rate kept", cnt1, 6);
      chk("err locked kept", 32'(locked), 1);

      phase_sync = 1;
      tick;
      phase_sync = 0;
      run(30);
      chk("sync ch0 e2", 32'(ce0[2]), 0);
      chk("sync ch0 e3", 32'(ce0[3]), 1);
      chk("sync ch1 e4", 32'(ce1[4]), 0);
      chk("sync ch1 e5", 32'(ce1[5]), 1);
      chk("sync both e15", 32'({ce0[15], ce1[15]}), 3);
      chk("sync both e30", 32'({ce0[30], ce1[30]}), 3);
      chk("sync lock kept", 32'(lk[1]), 1);

      phase_sync = 1;
      wr('{3'd1, 16'd1, 16'd2});
      phase_sync = 0;
      chk("sync+wr locked", 32'(locked), 0);
      count(20);
      chk("sync+wr ch1", cnt1, 10);

      cfg_valid = 1; cfg_ch = 0; cfg_num = 1; cfg_den = 4; rst = 1;
      tick;
      chk_reset_state;
      rst = 0; cfg_valid = 0;
      run(4);
      chk("rst discard e2", 32'(ce0[2]), 1);
      chk("rst discard e3", 32'(ce0[3]), 0);
      chk("rst discard e4", 32'(ce0[4]), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
